// File: rtl/lstm_pkg.sv
// Shared types for the LSTM window feeder.
//   WIDTH / FRAC : default sample word format (Q7.11, 18-bit signed)
//   fix_t        : signed sample/state word
//   feeder_state_t : feeder control states
package lstm_pkg;

  localparam int WIDTH = 18;
  localparam int FRAC  = 11;

  typedef logic signed [WIDTH-1:0] fix_t;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    ISSUE  = 2'd1,
    BUSY   = 2'd2,
    RESULT = 2'd3
  } feeder_state_t;

  // Counter increment that sticks at 4 (window depth).
  function automatic logic [2:0] sat_inc4(input logic [2:0] v);
    return (v >= 3'd4) ? 3'd4 : v + 3'd1;
  endfunction

endpackage

// File: rtl/lstm_window_feeder.sv
// Sliding-window front-end for lstm_4step_serial.
// Collects a valid/ready stream of signed samples into a 4-deep window,
// launches the LSTM with a one-cycle start pulse, waits for done and holds
// the returned c4/h4 behind a valid/ready result handshake. Optionally the
// returned state seeds c0/h0 of the next window.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_valid/s_ready/s_data    sample stream in
//   flush                     clear window and carried state (FILL only)
//   x1..x4, c0, h0            window (x1 oldest) and initial state to LSTM
//   lstm_start / lstm_done    LSTM launch pulse / completion
//   c4_in, h4_in              LSTM results
//   res_valid/res_ready       result handshake; res_c/res_h held results
//   res_count                 completed windows, wraps at 16 bits
module lstm_window_feeder #(
  parameter int WIDTH       = 18,
  parameter int FRAC        = 11,
  parameter int STRIDE      = 1,
  parameter int CARRY_STATE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_data,
  input  logic                    flush,
  output logic signed [WIDTH-1:0] x1,
  output logic signed [WIDTH-1:0] x2,
  output logic signed [WIDTH-1:0] x3,
  output logic signed [WIDTH-1:0] x4,
  output logic signed [WIDTH-1:0] c0,
  output logic signed [WIDTH-1:0] h0,
  output logic                    lstm_start,
  input  logic                    lstm_done,
  input  logic signed [WIDTH-1:0] c4_in,
  input  logic signed [WIDTH-1:0] h4_in,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [WIDTH-1:0] res_c,
  output logic signed [WIDTH-1:0] res_h,
  output logic [15:0]             res_count
);

  import lstm_pkg::*;

  // Configuration guard: stride beyond the window depth would never issue.
  if (STRIDE < 1 || STRIDE > 4 || FRAC >= WIDTH) begin : g_bad_cfg
    $error("lstm_window_feeder: STRIDE must be 1..4 and FRAC < WIDTH");
  end

  localparam logic [2:0] STRIDE_C = 3'(STRIDE);

  feeder_state_t          r_state;
  feeder_state_t          w_state_nxt;
  logic [2:0]             r_fill_cnt;
  logic [2:0]             r_new_cnt;
  logic [2:0]             w_fill_inc;
  logic [2:0]             w_new_inc;
  logic                   w_accept;
  logic                   w_flush;
  logic                   w_window_ready;
  logic                   w_capture;
  logic                   w_consume;
  logic                   r_lstm_start;
  logic                   r_res_valid;
  logic [15:0]            r_res_count;
  logic signed [WIDTH-1:0] r_x1, r_x2, r_x3, r_x4;
  logic signed [WIDTH-1:0] r_c0, r_h0;
  logic signed [WIDTH-1:0] r_res_c, r_res_h;

  // flush drops s_ready so a coincident sample is never accepted.
  assign s_ready        = (r_state == FILL) && !flush;
  assign w_accept       = s_valid && s_ready;
  assign w_flush        = flush && (r_state == FILL);
  assign w_fill_inc     = sat_inc4(r_fill_cnt);
  assign w_new_inc      = sat_inc4(r_new_cnt);
  // Decision uses the post-accept counts so the window issues on the
  // very edge that completes it.
  assign w_window_ready = w_accept && (w_fill_inc == 3'd4) && (w_new_inc >= STRIDE_C);
  assign w_capture      = (r_state == BUSY) && lstm_done;
  assign w_consume      = (r_state == RESULT) && res_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_window_ready) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = BUSY;
      BUSY:    if (lstm_done) w_state_nxt = RESULT;
      RESULT:  if (res_ready) w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_nxt;
  end

  // Control: counters, start pulse, result valid, window count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill_cnt   <= 3'd0;
      r_new_cnt    <= 3'd0;
      r_lstm_start <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_count  <= 16'd0;
    end else begin
      r_lstm_start <= w_window_ready;
      if (w_flush) begin
        r_fill_cnt <= 3'd0;
        r_new_cnt  <= 3'd0;
      end else if (w_accept) begin
        r_fill_cnt <= w_fill_inc;
        r_new_cnt  <= w_new_inc;
      end else if (w_consume) begin
        r_new_cnt  <= 3'd0;
      end
      if (w_capture) begin
        r_res_valid <= 1'b1;
        r_res_count <= r_res_count + 16'd1;
      end else if (w_consume) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  // Data: window shift register, initial state, captured results
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x1    <= '0;
      r_x2    <= '0;
      r_x3    <= '0;
      r_x4    <= '0;
      r_c0    <= '0;
      r_h0    <= '0;
      r_res_c <= '0;
      r_res_h <= '0;
    end else begin
      if (w_flush) begin
        r_x1 <= '0;
        r_x2 <= '0;
        r_x3 <= '0;
        r_x4 <= '0;
        r_c0 <= '0;
        r_h0 <= '0;
      end else if (w_accept) begin
        r_x1 <= r_x2;
        r_x2 <= r_x3;
        r_x3 <= r_x4;
        r_x4 <= s_data;
      end
      if (w_capture) begin
        r_res_c <= c4_in;
        r_res_h <= h4_in;
        if (CARRY_STATE != 0) begin
          r_c0 <= c4_in;
          r_h0 <= h4_in;
        end
      end
    end
  end

  assign x1         = r_x1;
  assign x2         = r_x2;
  assign x3         = r_x3;
  assign x4         = r_x4;
  assign c0         = r_c0;
  assign h0         = r_h0;
  assign lstm_start = r_lstm_start;
  assign res_valid  = r_res_valid;
  assign res_c      = r_res_c;
  assign res_h      = r_res_h;
  assign res_count  = r_res_count;

endmodule

// File: tb/tb_lstm_window_feeder.sv
// Directed bench for lstm_window_feeder: instance A (STRIDE=1, carried state)
// and instance B (STRIDE=2, no carried state) share clock and reset.
module tb_lstm_window_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A signals
  logic a_s_valid = 0, a_flush = 0, a_done = 0, a_res_ready = 0;
  logic signed [17:0] a_s_data = 0, a_c4 = 0, a_h4 = 0;
  logic a_s_ready, a_start, a_res_valid;
  logic signed [17:0] a_x1, a_x2, a_x3, a_x4, a_c0, a_h0, a_res_c, a_res_h;
  logic [15:0] a_res_count;

  // Instance B signals
  logic b_s_valid = 0, b_flush = 0, b_done = 0, b_res_ready = 0;
  logic signed [17:0] b_s_data = 0, b_c4 = 0, b_h4 = 0;
  logic b_s_ready, b_start, b_res_valid;
  logic signed [17:0] b_x1, b_x2, b_x3, b_x4, b_c0, b_h0, b_res_c, b_res_h;
  logic [15:0] b_res_count;

  lstm_window_feeder #(.WIDTH(18), .FRAC(11), .STRIDE(1), .CARRY_STATE(1)) dut_a (
    .clk(clk), .rst(rst), .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .flush(a_flush), .x1(a_x1), .x2(a_x2), .x3(a_x3), .x4(a_x4), .c0(a_c0), .h0(a_h0),
    .lstm_start(a_start), .lstm_done(a_done), .c4_in(a_c4), .h4_in(a_h4),
    .res_valid(a_res_valid), .res_ready(a_res_ready), .res_c(a_res_c), .res_h(a_res_h),
    .res_count(a_res_count));

  lstm_window_feeder #(.WIDTH(18), .FRAC(11), .STRIDE(2), .CARRY_STATE(0)) dut_b (
    .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .flush(b_flush), .x1(b_x1), .x2(b_x2), .x3(b_x3), .x4(b_x4), .c0(b_c0), .h0(b_h0),
    .lstm_start(b_start), .lstm_done(b_done), .c4_in(b_c4), .h4_in(b_h4),
    .res_valid(b_res_valid), .res_ready(b_res_ready), .res_c(b_res_c), .res_h(b_res_h),
    .res_count(b_res_count));

  function automatic logic [71:0] win(input int p, input int q, input int r, input int s);
    return {18'(p), 18'(q), 18'(r), 18'(s)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input int d);
    a_s_valid = 1'b1;
    a_s_data  = 18'(d);
    tick();
    a_s_valid = 1'b0;
  endtask

  task automatic b_push(input int d);
    b_s_valid = 1'b1;
    b_s_data  = 18'(d);
    tick();
    b_s_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    n_cmp++; if ({a_x1, a_x2, a_x3, a_x4} !== win(0, 0, 0, 0)) begin n_bad++; $display("FAIL reset_window got=%h want=0", {a_x1, a_x2, a_x3, a_x4}); end
    n_cmp++; if ({a_c0, a_h0, a_res_c, a_res_h} !== 72'd0) begin n_bad++; $display("FAIL reset_state got c0=%0d h0=%0d rc=%0d rh=%0d want 0", a_c0, a_h0, a_res_c, a_res_h); end
    n_cmp++; if ({a_start, a_res_valid, a_s_ready} !== 3'b001) begin n_bad++; $display("FAIL reset_ctrl got start/rv/srdy=%b want 001", {a_start, a_res_valid, a_s_ready}); end
    n_cmp++; if (a_res_count !== 16'd0) begin n_bad++; $display("FAIL reset_count got=%0d want=0", a_res_count); end
    n_cmp++; if ({b_start, b_res_valid, b_s_ready, b_res_count} !== {3'b001, 16'd0}) begin n_bad++; $display("FAIL reset_b got start/rv/srdy=%b cnt=%0d", {b_start, b_res_valid, b_s_ready}, b_res_count); end
  endtask

  task automatic test_window;
    int vals[4] = '{0, 1024, 512, 2048};
    for (int i = 0; i < 4; i++) begin
      a_s_valid = 1'b1;
      a_s_data  = 18'(vals[i]);
      tick();
      n_cmp++; if (a_start !== (i == 3)) begin n_bad++; $display("FAIL win_start_%0d got=%b want=%b", i, a_start, (i == 3)); end
    end
    a_s_valid = 1'b0;
    n_cmp++; if ({a_x1, a_x2, a_x3, a_x4} !== win(0, 1024, 512, 2048)) begin n_bad++; $display("FAIL win_x got=%h want=%h", {a_x1, a_x2, a_x3, a_x4}, win(0, 1024, 512, 2048)); end
    n_cmp++; if ({a_c0, a_h0} !== 36'd0) begin n_bad++; $display("FAIL win_c0h0 got=%0d/%0d want=0/0", a_c0, a_h0); end
    n_cmp++; if (a_s_ready !== 1'b0) begin n_bad++; $display("FAIL win_issue_srdy got=%b want=0", a_s_ready); end
    a_s_valid = 1'b1;
    a_s_data  = 18'd4095;
    tick();
    a_s_valid = 1'b0;
    n_cmp++; if ({a_start, a_s_ready} !== 2'b00) begin n_bad++; $display("FAIL win_busy got start/srdy=%b want 00", {a_start, a_s_ready}); end
  endtask

  task automatic test_result;
    repeat (9) tick();
    n_cmp++; if ({a_x1, a_x2, a_x3, a_x4} !== win(0, 1024, 512, 2048) || a_s_ready !== 1'b0) begin n_bad++; $display("FAIL busy_hold got x=%h srdy=%b", {a_x1, a_x2, a_x3, a_x4}, a_s_ready); end
    n_cmp++; if (a_res_valid !== 1'b0) begin n_bad++; $display("FAIL busy_rv got=%b want=0", a_res_valid); end
    a_done = 1'b1; a_c4 = 18'sd1500; a_h4 = 18'sd700;
    tick();
    a_done = 1'b0; a_c4 = 18'sd0; a_h4 = 18'sd0;
    n_cmp++; if ({a_res_valid, a_res_c, a_res_h} !== {1'b1, 18'sd1500, 18'sd700}) begin n_bad++; $display("FAIL res_capture got rv=%b c=%0d h=%0d want 1/1500/700", a_res_valid, a_res_c, a_res_h); end
    n_cmp++; if (a_res_count !== 16'd1) begin n_bad++; $display("FAIL res_count got=%0d want=1", a_res_count); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({a_res_valid, a_res_c, a_res_h, a_s_ready} !== {1'b1, 18'sd1500, 18'sd700, 1'b0}) begin n_bad++; $display("FAIL res_hold_%0d got rv=%b c=%0d h=%0d srdy=%b", i, a_res_valid, a_res_c, a_res_h, a_s_ready); end
    end
    a_res_ready = 1'b1;
    tick();
    a_res_ready = 1'b0;
    n_cmp++; if ({a_res_valid, a_s_ready} !== 2'b01) begin n_bad++; $display("FAIL res_consume got rv/srdy=%b want 01", {a_res_valid, a_s_ready}); end
    n_cmp++; if ({a_c0, a_h0} !== {18'sd1500, 18'sd700}) begin n_bad++; $display("FAIL carry got c0=%0d h0=%0d want 1500/700", a_c0, a_h0); end
  endtask

  task automatic test_slide;
    a_push(3072);
    n_cmp++; if (a_start !== 1'b1) begin n_bad++; $display("FAIL slide_start got=%b want=1", a_start); end
    n_cmp++; if ({a_x1, a_x2, a_x3, a_x4} !== win(1024, 512, 2048, 3072)) begin n_bad++; $display("FAIL slide_x got=%h want=%h", {a_x1, a_x2, a_x3, a_x4}, win(1024, 512, 2048, 3072)); end
    tick();
    a_done = 1'b1; a_c4 = -18'sd1500; a_h4 = -18'sd1;
    tick();
    a_done = 1'b0;
    n_cmp++; if ({a_res_c, a_res_h, a_res_count} !== {-18'sd1500, -18'sd1, 16'd2}) begin n_bad++; $display("FAIL slide_res got c=%0d h=%0d cnt=%0d want -1500/-1/2", a_res_c, a_res_h, a_res_count); end
    a_res_ready = 1'b1;
    tick();
    a_res_ready = 1'b0;
    n_cmp++; if ({a_c0, a_h0} !== {-18'sd1500, -18'sd1}) begin n_bad++; $display("FAIL slide_carry got c0=%0d h0=%0d want -1500/-1", a_c0, a_h0); end
  endtask

  task automatic test_flush;
    int pre[3]  = '{10, 20, 30};
    int post[4] = '{40, 50, 60, 70};
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    n_cmp++; if ({a_x1, a_x2, a_x3, a_x4, a_c0, a_h0} !== 108'd0) begin n_bad++; $display("FAIL flush_clear got x=%h c0=%0d h0=%0d", {a_x1, a_x2, a_x3, a_x4}, a_c0, a_h0); end
    for (int i = 0; i < 3; i++) begin
      a_push(pre[i]);
      n_cmp++; if (a_start !== 1'b0) begin n_bad++; $display("FAIL flush_pre_start_%0d got=%b want=0", i, a_start); end
    end
    a_flush = 1'b1; a_s_valid = 1'b1; a_s_data = 18'sd999;
    #1;
    n_cmp++; if (a_s_ready !== 1'b0) begin n_bad++; $display("FAIL flush_srdy got=%b want=0", a_s_ready); end
    tick();
    a_flush = 1'b0; a_s_valid = 1'b0;
    n_cmp++; if ({a_x1, a_x2, a_x3, a_x4} !== win(0, 0, 0, 0)) begin n_bad++; $display("FAIL flush_drop got x=%h want 0", {a_x1, a_x2, a_x3, a_x4}); end
    for (int i = 0; i < 4; i++) begin
      a_push(post[i]);
      n_cmp++; if (a_start !== (i == 3)) begin n_bad++; $display("FAIL flush_post_start_%0d got=%b want=%b", i, a_start, (i == 3)); end
    end
    n_cmp++; if ({a_x1, a_x2, a_x3, a_x4} !== win(40, 50, 60, 70)) begin n_bad++; $display("FAIL flush_window got=%h want=%h", {a_x1, a_x2, a_x3, a_x4}, win(40, 50, 60, 70)); end
    tick();
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    n_cmp++; if ({a_x1, a_x2, a_x3, a_x4} !== win(40, 50, 60, 70) || a_s_ready !== 1'b0) begin n_bad++; $display("FAIL flush_busy_ignored got x=%h srdy=%b", {a_x1, a_x2, a_x3, a_x4}, a_s_ready); end
  endtask

  task automatic test_reset_busy;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_done = 1'b1; a_c4 = 18'sd77; a_h4 = 18'sd88;
    tick();
    a_done = 1'b0;
    n_cmp++; if ({a_x1, a_x2, a_x3, a_x4, a_c0, a_h0} !== 108'd0) begin n_bad++; $display("FAIL rstbusy_data got x=%h c0=%0d h0=%0d", {a_x1, a_x2, a_x3, a_x4}, a_c0, a_h0); end
    n_cmp++; if ({a_res_c, a_res_h} !== 36'd0 || a_res_valid !== 1'b0) begin n_bad++; $display("FAIL rstbusy_res got rv=%b c=%0d h=%0d", a_res_valid, a_res_c, a_res_h); end
    n_cmp++; if (a_res_count !== 16'd0) begin n_bad++; $display("FAIL rstbusy_count got=%0d want=0", a_res_count); end
    n_cmp++; if ({a_s_ready, a_start} !== 2'b10) begin n_bad++; $display("FAIL rstbusy_ctrl got srdy/start=%b want 10", {a_s_ready, a_start}); end
  endtask

  task automatic test_stride2;
    int vals[4] = '{100, 200, 300, 400};
    for (int i = 0; i < 4; i++) begin
      b_push(vals[i]);
      n_cmp++; if (b_start !== (i == 3)) begin n_bad++; $display("FAIL s2_fill_start_%0d got=%b want=%b", i, b_start, (i == 3)); end
    end
    tick();
    b_done = 1'b1; b_c4 = 18'sd1500; b_h4 = 18'sd700;
    tick();
    b_done = 1'b0;
    n_cmp++; if ({b_res_valid, b_res_c, b_res_h, b_res_count} !== {1'b1, 18'sd1500, 18'sd700, 16'd1}) begin n_bad++; $display("FAIL s2_res got rv=%b c=%0d h=%0d cnt=%0d", b_res_valid, b_res_c, b_res_h, b_res_count); end
    b_res_ready = 1'b1;
    tick();
    b_res_ready = 1'b0;
    n_cmp++; if ({b_c0, b_h0} !== 36'd0) begin n_bad++; $display("FAIL nocarry got c0=%0d h0=%0d want 0/0", b_c0, b_h0); end
    b_push(500);
    n_cmp++; if ({b_start, b_s_ready} !== 2'b01) begin n_bad++; $display("FAIL s2_one_new got start/srdy=%b want 01", {b_start, b_s_ready}); end
    b_push(600);
    n_cmp++; if (b_start !== 1'b1) begin n_bad++; $display("FAIL s2_two_new got start=%b want=1", b_start); end
    n_cmp++; if ({b_x1, b_x2, b_x3, b_x4} !== win(300, 400, 500, 600)) begin n_bad++; $display("FAIL s2_window got=%h want=%h", {b_x1, b_x2, b_x3, b_x4}, win(300, 400, 500, 600)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_window();
    test_result();
    test_slide();
    test_flush();
    test_reset_busy();
    test_stride2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
